// File: rtl/im_loader.sv
// im_loader: writer side of the 9-bit instruction memory.
// Reassembles a byte stream (16-bit count header, then lo/hi byte pairs)
// into instruction words and writes them from address 0 upward, holding the
// CPU until the load completes.
// Optional macro IM_LOADER_CHECKSUM_EN: trailing XOR checksum byte.
module im_loader #(
  parameter int SIZE = 1024,
  parameter int AW   = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [8:0]    wr_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR_L, HDR_H, INS_L, INS_H, CHK, DONE, ERR} st_t;
`else
  typedef enum logic [2:0] {HDR_L, HDR_H, INS_L, INS_H, DONE, ERR} st_t;
`endif

  localparam logic [16:0] SIZE17 = 17'(SIZE);

  st_t         state, nxt;
  logic [15:0] cnt_q;
  logic [15:0] wcnt;
  logic [7:0]  lo_q;
  logic        acc, wr_go, rdy_n;
  logic [15:0] cnt_full;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  assign acc      = in_valid && in_ready;
  assign cnt_full = {in_data, cnt_q[7:0]};

  // Next-state, write fire and next-cycle ready decode.
  always_comb begin
    nxt   = state;
    wr_go = 1'b0;
    rdy_n = 1'b0;
    case (state)
      HDR_L: if (acc) nxt = HDR_H;
      HDR_H: if (acc) begin
        if (cnt_full == 16'd0)
`ifdef IM_LOADER_CHECKSUM_EN
          nxt = CHK;
`else
          nxt = DONE;
`endif
        else if ({1'b0, cnt_full} > SIZE17) nxt = ERR;
        else nxt = INS_L;
      end
      INS_L: if (acc) nxt = INS_H;
      INS_H: if (acc) begin
        if (in_data[7:1] != 7'd0) nxt = ERR;
        else begin
          wr_go = 1'b1;
          if (wcnt == cnt_q - 16'd1)
`ifdef IM_LOADER_CHECKSUM_EN
            nxt = CHK;
`else
            nxt = DONE;
`endif
          else nxt = INS_L;
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: if (acc) nxt = (in_data == xor_q) ? DONE : ERR;
`endif
      DONE:    nxt = DONE;
      ERR:     nxt = ERR;
      default: nxt = ERR;
    endcase
    rdy_n = (nxt != DONE) && (nxt != ERR);
  end

  // State, registered outputs and stream datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= HDR_L;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      cnt_q    <= '0;
      wcnt     <= '0;
      lo_q     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state    <= nxt;
      in_ready <= rdy_n;
      wr_en    <= wr_go;
      done     <= (nxt == DONE);
      err      <= (nxt == ERR);
      cpu_hold <= (nxt != DONE);
      if (wr_go) begin
        wr_addr <= wcnt[AW-1:0];
        wr_data <= {in_data[0], lo_q};
        wcnt    <= wcnt + 16'd1;
      end
      if (acc && state == HDR_L) cnt_q[7:0]  <= in_data;
      if (acc && state == HDR_H) cnt_q[15:8] <= in_data;
      if (acc && state == INS_L) lo_q        <= in_data;
`ifdef IM_LOADER_CHECKSUM_EN
      if (acc && state != CHK) xor_q <= xor_q ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: stream loads, bubbles, errors, mid-load reset.
module tb_im_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_en, cpu_hold, done, err;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;

  int checks = 0, failures = 0;
  int cyc = 0, hs = -10;
  logic [7:0] txor = '0;
  int q_addr[$], q_data[$], q_lat[$], q_done[$], q_hold[$];
  bit prev_wr = 0, consec = 0;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  im_loader #(.SIZE(1024), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(int'(wr_addr));
      q_data.push_back(int'(wr_data));
      q_lat.push_back(int'(cyc == hs));
      q_done.push_back(int'(done));
      q_hold.push_back(int'(cpu_hold));
      if (prev_wr) consec = 1;
    end
    prev_wr = wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    q_addr.delete(); q_data.delete(); q_lat.delete(); q_done.delete(); q_hold.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txor = '0;
    clr_log();
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    in_data = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      hs = cyc;
      in_valid = 1'b0;
      txor = txor ^ b;
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_ck();
    if (CK) send(txor, 0);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic basic(input int gap, input string t);
    send(8'h03, gap); send(8'h00, gap);
    send(8'hF0, gap); send(8'h00, gap);
    send(8'h00, gap); send(8'h01, gap);
    send(8'h1E, gap); send(8'h01, gap);
    send_ck();
    settle();
    chk({t, "_nwr"}, q_addr.size(), 3);
    if (q_addr.size() == 3) begin
      chk({t, "_a0"}, q_addr[0], 0); chk({t, "_d0"}, q_data[0], 9'h0F0);
      chk({t, "_a1"}, q_addr[1], 1); chk({t, "_d1"}, q_data[1], 9'h100);
      chk({t, "_a2"}, q_addr[2], 2); chk({t, "_d2"}, q_data[2], 9'h11E);
      chk({t, "_lat"}, q_lat[0] + q_lat[1] + q_lat[2], 3);
      chk({t, "_done_at_wr"}, q_done[2], CK ? 0 : 1);
      chk({t, "_hold_at_wr"}, q_hold[2], CK ? 1 : 0);
    end
    chk({t, "_done"}, done, 1);
    chk({t, "_hold"}, cpu_hold, 0);
    chk({t, "_err"}, err, 0);
    chk({t, "_rdy"}, in_ready, 0);
    chk({t, "_addr_hold"}, wr_addr, 2);
  endtask

  task automatic chk_reset_vals(input string t);
    chk({t, "_rdy"}, in_ready, 0);
    chk({t, "_wr"}, wr_en, 0);
    chk({t, "_addr"}, wr_addr, 0);
    chk({t, "_data"}, wr_data, 0);
    chk({t, "_hold"}, cpu_hold, 1);
    chk({t, "_done"}, done, 0);
    chk({t, "_err"}, err, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk_reset_vals("rst");
    @(negedge clk);
    chk("rst_rdy_up", in_ready, 1);

    // Basic load, back-to-back
    basic(0, "basic");
    @(negedge clk); in_data = 8'h55; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_noaccept", in_ready, 0);
    chk("done_nowr", q_addr.size(), 3);
    in_valid = 1'b0;

    // Empty program
    do_reset();
    send(8'h00, 0); send(8'h00, 0); send_ck();
    settle();
    chk("empty_nwr", q_addr.size(), 0);
    chk("empty_done", done, 1);
    chk("empty_hold", cpu_hold, 0);
    chk("empty_rdy", in_ready, 0);

    // Oversize count 1025
    do_reset();
    send(8'h01, 0); send(8'h04, 0);
    settle();
    chk("ovr_err", err, 1);
    chk("ovr_hold", cpu_hold, 1);
    chk("ovr_done", done, 0);
    chk("ovr_rdy", in_ready, 0);
    chk("ovr_nwr", q_addr.size(), 0);

    // Bad hi byte
    do_reset();
    send(8'h01, 0); send(8'h00, 0); send(8'h55, 0); send(8'h02, 0);
    settle();
    chk("badhi_err", err, 1);
    chk("badhi_done", done, 0);
    chk("badhi_nwr", q_addr.size(), 0);

    // Stalled basic load
    do_reset();
    basic(3, "stall");

    // Mid-load reset of a second stream
    do_reset();
    send(8'h02, 0); send(8'h00, 0); send(8'h11, 0); send(8'h01, 0);
    settle();
    chk("mid_nwr", q_addr.size(), 1);
    do_reset();
    chk_reset_vals("midrst");

    // Fresh stream after reset
    send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'h00, 0); send_ck();
    settle();
    chk("fresh_nwr", q_addr.size(), 1);
    if (q_addr.size() == 1) begin
      chk("fresh_a0", q_addr[0], 0);
      chk("fresh_d0", q_data[0], 9'h0AA);
    end
    chk("fresh_done", done, 1);

`ifdef IM_LOADER_CHECKSUM_EN
    // Checksum good
    do_reset();
    send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'h01, 0);
    send(8'hAA, 0);
    settle();
    chk("ck_good_done", done, 1);
    chk("ck_good_err", err, 0);
    chk("ck_good_d0", q_data.size() == 1 ? q_data[0] : -1, 9'h1AA);
    // Checksum bad
    do_reset();
    send(8'h01, 0); send(8'h00, 0); send(8'hAA, 0); send(8'h01, 0);
    send(8'hAB, 0);
    settle();
    chk("ck_bad_err", err, 1);
    chk("ck_bad_done", done, 0);
    chk("ck_bad_hold", cpu_hold, 1);
    chk("ck_bad_nwr", q_addr.size(), 1);
`endif

    chk("no_consec_wr", consec, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
